// File: rtl/delay_prog.sv
// Runtime-programmable, valid-tagged multi-channel delay line with stall support.
// A delay change flushes stored valids, and busy covers the settle window that follows.
module delay_prog #(
    parameter int W     = 8,
    parameter int CH    = 1,
    parameter int MAX_N = 16,
    parameter int AW    = $clog2(MAX_N + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [CH*W-1:0] din,
    input  logic            din_vld,
    input  logic [AW-1:0]   dly,
    output logic [CH*W-1:0] dout,
    output logic            dout_vld,
    output logic            busy
);
    localparam int DW = CH * W;
    localparam int PW = (MAX_N > 1) ? $clog2(MAX_N) : 1;
    localparam int SW = AW + 1;

    typedef enum logic {RUN, SETTLE} state_e;

    logic [DW-1:0]    data_q [MAX_N];
    logic [MAX_N-1:0] vld_q;
    logic [PW-1:0]    wp_q;
    logic [PW-1:0]    wp_d;
    logic [PW-1:0]    rp;
    logic [SW-1:0]    rp_ext;
    logic [AW-1:0]    dly_q;
    logic [AW-1:0]    dly_eff;
    logic [AW-1:0]    cnt_q;
    logic             chg;
    state_e           state_q;
    logic             busy_q;

    always_comb begin
        dly_eff = (dly > AW'(MAX_N)) ? AW'(MAX_N) : dly;
        chg     = (dly_eff != dly_q);
        wp_d    = (wp_q == PW'(MAX_N - 1)) ? '0 : wp_q + 1'b1;
        // One extra bit so that wp + MAX_N cannot overflow before the subtraction.
        if (SW'(wp_q) >= SW'(dly_q)) begin
            rp_ext = SW'(wp_q) - SW'(dly_q);
        end else begin
            rp_ext = SW'(wp_q) + SW'(MAX_N) - SW'(dly_q);
        end
        rp = PW'(rp_ext);
    end

    // NOTE: the storage array is reset on purpose, because entries must read back as zero right after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_N; i++) data_q[i] <= '0;
            vld_q   <= '0;
            wp_q    <= '0;
            dly_q   <= AW'(MAX_N);
            cnt_q   <= '0;
            state_q <= RUN;
            busy_q  <= 1'b0;
        end else begin
            if (chg) begin
                vld_q   <= '0;
                dly_q   <= dly_eff;
                cnt_q   <= dly_eff;
                state_q <= (dly_eff != '0) ? SETTLE : RUN;
                busy_q  <= (dly_eff != '0);
            end else if (en && state_q == SETTLE) begin
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == AW'(1)) begin
                    state_q <= RUN;
                    busy_q  <= 1'b0;
                end
            end
            // NOTE: this later non-blocking write to vld_q[wp_q] overrides the flush above for the entry being written.
            if (en) begin
                data_q[wp_q] <= din;
                vld_q[wp_q]  <= din_vld;
                wp_q         <= wp_d;
            end
        end
    end

    always_comb begin
        if (dly_q == '0) begin
            dout     = din;
            dout_vld = din_vld;
        end else begin
            dout     = data_q[rp];
            dout_vld = vld_q[rp];
        end
    end

    assign busy = busy_q;

endmodule
